ysyx_25060170_mem_arbiter: RTL and testbench
============================================

# ysyx_25060170_mem_arbiter

Shares the core's single memory port between the instruction-fetch unit (IFU) and the load/store stage (LSU, fed by the EX→LS pipeline register). It accepts one request at a time and latches it. It issues the request on the memory port with a valid/ready handshake, waits for the response, and returns registered read data to the owner. When both requesters collide it grants them round-robin, and it can discard an in-flight fetch when the front end flushes.

## Interface
Parameters:
- AW, 32, address width (matches `ysyx_25060170_PC`)
- DW, 32, data width (matches `ysyx_25060170_DATA`)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  fetch request
- ifu_req_addr  in  AW  fetch address
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_flush  in  1  discard current/outstanding fetch
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_resp_data  out  DW  fetched instruction
- lsu_req_valid  in  1  load/store request
- lsu_req_wen  in  1  1 = store
- lsu_req_addr  in  AW  data address
- lsu_req_wdata  in  DW  store data
- lsu_req_wstrb  in  4  byte strobes
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_resp_valid  out  1  load data / store done (1-cycle pulse)
- lsu_resp_rdata  out  DW  load data (0 for stores)
- mem_req_valid  out  1  memory request
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb  out  1/AW/DW/4  latched request fields
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response
- mem_resp_rdata  in  DW  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ_IFU, WAIT_IFU, REQ_LSU, WAIT_LSU. Encodings live in the shared package.
- In IDLE:
  - lsu_req_ready and ifu_req_ready are combinational.
  - If only one requester is valid, that one is granted.
  - If both are valid, grant goes to the requester not granted last (last_grant flag; reset value selects LSU first).
  - ifu_req_ready is gated by !ifu_flush, so a fetch is never accepted in a flush cycle.
- On grant: latch addr/wdata/wstrb/wen (IFU: wen=0, wstrb=0, wdata=0), update last_grant, then go to REQ_x.
- REQ_x: mem_req_valid=1 with the latched fields. Fields are held stable until mem_req_ready=1, then go to WAIT_x.
- WAIT_x: on mem_resp_valid, register the data into x_resp_data and pulse x_resp_valid for one cycle, then go to IDLE. For stores, lsu_resp_rdata=0.
- Flush: if ifu_flush=1 in REQ_IFU or WAIT_IFU, set drop=1. The transaction still completes on the memory port; the response is consumed but ifu_resp_valid stays 0. drop clears on return to IDLE. A flush in WAIT_IFU in the same cycle as mem_resp_valid also suppresses that response. LSU transactions ignore ifu_flush.
- mem_resp_valid outside a WAIT state is ignored.
- Only one outstanding memory transaction is allowed; no request is accepted unless the state is IDLE.

## Timing
- Reset (rst=0, async): state=IDLE, last_grant=IFU (LSU wins the first tie), drop=0. All outputs are 0, including mem_req_*, resp_valid/data, ready, and busy. Reset mid-transaction abandons it; the memory is reset by the same rst.
- Request accepted in cycle T → mem_req_valid from T+1. A response in cycle R (≥ handshake+1) → x_resp_valid in R+1.
- Best-case fetch: accept T, handshake T+1, mem_resp T+2, ifu_resp_valid T+3.
- The FSM reaches IDLE on the same edge that registers the response, so a new request can be accepted in the cycle x_resp_valid is high. The back-to-back issue rate is one transaction per 3 cycles (zero-wait memory).
- The requester must hold valid and fields until ready. The arbiter holds mem_req_* until mem_req_ready.

## Structure
- The shared `define.v` package holds state encodings (`ysyx_25060170_ARB_IDLE` …), widths (`ysyx_25060170_PC`, `ysyx_25060170_DATA`), and `ysyx_25060170_RSTABLE`-style reset-level constants (active-low).
- Single module, no sub-modules. The round-robin choice is one flag plus a priority mux inside it.

## Test plan
- Single fetch: ifu_req addr=0x8000_0000, memory returns 0x0000_0413 one cycle after handshake → ifu_resp_valid pulse at T+3, data 0x0000_0413; lsu_resp_valid stays 0.
- Collision after reset: both valid in same cycle → LSU granted first (lsu_req_ready=1, ifu_req_ready=0). IFU is granted on the next IDLE. A third tie goes to LSU.
- Store: lsu wen=1, addr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF; mem_req_ready held 0 for 3 cycles → mem_req fields stable throughout. lsu_resp_valid pulses with rdata=0.
- Flush: ifu_flush pulsed during WAIT_IFU; mem returns 0x1234_5678 → no ifu_resp_valid, FSM returns IDLE, next fetch serviced normally. ifu_flush with ifu_req_valid in IDLE → ifu_req_ready=0.
- Async reset: assert rst=0 mid REQ_LSU between clock edges → mem_req_valid and busy drop immediately. After release, the first tie grants LSU.
- Spurious mem_resp_valid in IDLE → no resp pulse, state unchanged.

Source files
------------

// File: rtl/ysyx_25060170_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state and grant encodings,
// datapath widths and the reset level.
package ysyx_25060170_mem_arbiter_pkg;

    localparam int ysyx_25060170_PC   = 32;
    localparam int ysyx_25060170_DATA = 32;

    // Reset is asserted when rst equals this level.
    localparam logic ysyx_25060170_RSTABLE = 1'b0;

    typedef enum logic [2:0] {
        ysyx_25060170_ARB_IDLE     = 3'd0,
        ysyx_25060170_ARB_REQ_IFU  = 3'd1,
        ysyx_25060170_ARB_WAIT_IFU = 3'd2,
        ysyx_25060170_ARB_REQ_LSU  = 3'd3,
        ysyx_25060170_ARB_WAIT_LSU = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

endpackage

// File: rtl/ysyx_25060170_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Ports: ifu_req/resp, lsu_req/resp, mem_req/resp handshakes, busy, clk, rst.
module ysyx_25060170_mem_arbiter
    import ysyx_25060170_mem_arbiter_pkg::*;
#(
    parameter int AW = ysyx_25060170_PC,
    parameter int DW = ysyx_25060170_DATA
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_req_ready,
    input  logic          ifu_flush,
    output logic          ifu_resp_valid,
    output logic [DW-1:0] ifu_resp_data,

    input  logic          lsu_req_valid,
    input  logic          lsu_req_wen,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [DW-1:0] lsu_req_wdata,
    input  logic [3:0]    lsu_req_wstrb,
    output logic          lsu_req_ready,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_resp_rdata,

    output logic          mem_req_valid,
    output logic          mem_req_wen,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    output logic [3:0]    mem_req_wstrb,
    input  logic          mem_req_ready,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_rdata,

    output logic          busy
);

    arb_state_t    state_q, state_d;
    grant_t        last_grant_q, last_grant_d;
    logic          drop_q, drop_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          ifu_resp_valid_q, ifu_resp_valid_d;
    logic [DW-1:0] ifu_resp_data_q, ifu_resp_data_d;
    logic          lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DW-1:0] lsu_resp_data_q, lsu_resp_data_d;

    logic          in_reset;
    logic          ifu_ok;
    logic          lsu_ok;

    // Ready is combinational in IDLE, so hold it low while reset is asserted.
    assign in_reset = (rst == ysyx_25060170_RSTABLE);
    assign ifu_ok   = ifu_req_valid && !ifu_flush;
    assign lsu_ok   = lsu_req_valid;

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        drop_d           = drop_q;
        wen_d            = wen_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wstrb_d          = wstrb_q;
        ifu_resp_valid_d = 1'b0;
        ifu_resp_data_d  = ifu_resp_data_q;
        lsu_resp_valid_d = 1'b0;
        lsu_resp_data_d  = lsu_resp_data_q;
        ifu_req_ready    = 1'b0;
        lsu_req_ready    = 1'b0;

        unique case (state_q)
            ysyx_25060170_ARB_IDLE: begin
                drop_d = 1'b0;
                if (!in_reset) begin
                    // On a tie the side not served last wins.
                    if (lsu_ok && (!ifu_ok || last_grant_q == GRANT_IFU)) begin
                        lsu_req_ready = 1'b1;
                        last_grant_d  = GRANT_LSU;
                        wen_d         = lsu_req_wen;
                        addr_d        = lsu_req_addr;
                        wdata_d       = lsu_req_wdata;
                        wstrb_d       = lsu_req_wstrb;
                        state_d       = ysyx_25060170_ARB_REQ_LSU;
                    end else if (ifu_ok) begin
                        ifu_req_ready = 1'b1;
                        last_grant_d  = GRANT_IFU;
                        wen_d         = 1'b0;
                        addr_d        = ifu_req_addr;
                        wdata_d       = '0;
                        wstrb_d       = 4'h0;
                        state_d       = ysyx_25060170_ARB_REQ_IFU;
                    end
                end
            end
            ysyx_25060170_ARB_REQ_IFU: begin
                if (ifu_flush) drop_d = 1'b1;
                if (mem_req_ready) state_d = ysyx_25060170_ARB_WAIT_IFU;
            end
            ysyx_25060170_ARB_WAIT_IFU: begin
                if (mem_resp_valid) begin
                    // A flush arriving with the response still kills it.
                    if (!(drop_q || ifu_flush)) begin
                        ifu_resp_valid_d = 1'b1;
                        ifu_resp_data_d  = mem_resp_rdata;
                    end
                    drop_d  = 1'b0;
                    state_d = ysyx_25060170_ARB_IDLE;
                end else if (ifu_flush) begin
                    drop_d = 1'b1;
                end
            end
            ysyx_25060170_ARB_REQ_LSU: begin
                if (mem_req_ready) state_d = ysyx_25060170_ARB_WAIT_LSU;
            end
            ysyx_25060170_ARB_WAIT_LSU: begin
                if (mem_resp_valid) begin
                    lsu_resp_valid_d = 1'b1;
                    lsu_resp_data_d  = wen_q ? '0 : mem_resp_rdata;
                    state_d          = ysyx_25060170_ARB_IDLE;
                end
            end
            default: state_d = ysyx_25060170_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == ysyx_25060170_RSTABLE) begin
            state_q          <= ysyx_25060170_ARB_IDLE;
            last_grant_q     <= GRANT_IFU;
            drop_q           <= 1'b0;
            wen_q            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= 4'h0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_data_q  <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            drop_q           <= drop_d;
            wen_q            <= wen_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wstrb_q          <= wstrb_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_resp_data_q  <= ifu_resp_data_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_resp_data_q  <= lsu_resp_data_d;
        end
    end

    // Request fields are only driven while a request is on the port.
    assign mem_req_valid  = (state_q == ysyx_25060170_ARB_REQ_IFU) ||
                            (state_q == ysyx_25060170_ARB_REQ_LSU);
    assign mem_req_wen    = mem_req_valid ? wen_q   : 1'b0;
    assign mem_req_addr   = mem_req_valid ? addr_q  : '0;
    assign mem_req_wdata  = mem_req_valid ? wdata_q : '0;
    assign mem_req_wstrb  = mem_req_valid ? wstrb_q : 4'h0;

    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_data  = ifu_resp_data_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_rdata = lsu_resp_data_q;
    assign busy           = (state_q != ysyx_25060170_ARB_IDLE);

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Directed testbench for ysyx_25060170_mem_arbiter.
// Ports driven by scenario tasks; memory side is driven by hand.
module tb_ysyx_25060170_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_flush;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        busy;

    int total;
    int bad;

    ysyx_25060170_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_flush      (ifu_flush),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wstrb  (lsu_req_wstrb),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake on this cycle, respond on the next; ends in the cycle
    // where the response pulse is visible.
    task automatic mem_cycle(input logic [31:0] data);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = data;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        ifu_flush     = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wdata = 32'h0;
        lsu_req_wstrb = 4'h0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        tick();
        tick();
        total++;
        if ({busy, mem_req_valid, ifu_req_ready, lsu_req_ready,
             ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {busy, mem_req_valid, ifu_req_ready, lsu_req_ready,
                      ifu_resp_valid, lsu_resp_valid});
        end
        total++;
        if ({mem_req_addr, ifu_resp_data, lsu_resp_rdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0",
                     {mem_req_addr, ifu_resp_data, lsu_resp_rdata});
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_collision();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0200;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = 32'h0000_0100;
        #1;
        total++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL tie1 got=%b want=10", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        lsu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_0100}) begin
            bad++;
            $display("FAIL tie1_addr got=%h want=100", mem_req_addr);
        end
        mem_cycle(32'hAAAA_0001);
        total++;
        if ({lsu_resp_valid, lsu_resp_rdata, ifu_resp_valid} !==
            {1'b1, 32'hAAAA_0001, 1'b0}) begin
            bad++;
            $display("FAIL load_resp got=%b %h want=1 aaaa0001",
                     lsu_resp_valid, lsu_resp_rdata);
        end
        lsu_req_valid = 1'b1;
        #1;
        total++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tie2 got=%b want=01", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen} !==
            {1'b1, 32'h0000_0200, 1'b0}) begin
            bad++;
            $display("FAIL tie2_addr got=%h want=200", mem_req_addr);
        end
        mem_cycle(32'hBBBB_0002);
        ifu_req_valid = 1'b1;
        #1;
        total++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL tie3 got=%b want=10", {lsu_req_ready, ifu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_cycle(32'h0);
        tick();
    endtask

    task automatic test_single_fetch();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_ready got=%b want=10",
                     {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, busy} !==
            {1'b1, 1'b0, 32'h8000_0000, 4'h0, 1'b1}) begin
            bad++;
            $display("FAIL fetch_req got=%b %h want=1 80000000",
                     mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0000_0413;
        total++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_wait got=%b want=00",
                     {mem_req_valid, ifu_resp_valid});
        end
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, ifu_resp_data, lsu_resp_valid, busy} !==
            {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_resp got=%b %h want=1 00000413",
                     ifu_resp_valid, ifu_resp_data);
        end
        tick();
        total++;
        if (ifu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_pulse got=%b want=0", ifu_resp_valid);
        end
    endtask

    task automatic test_store();
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wstrb = 4'hF;
        tick();
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wdata = 32'h0;
        lsu_req_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
                 mem_req_wstrb} !==
                {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
                bad++;
                $display("FAIL store_hold%0d got=%b %b %h %h %h", i,
                         mem_req_valid, mem_req_wen, mem_req_addr,
                         mem_req_wdata, mem_req_wstrb);
            end
            tick();
        end
        mem_cycle(32'h5555_5555);
        total++;
        if ({lsu_resp_valid, lsu_resp_rdata} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL store_resp got=%b %h want=1 0",
                     lsu_resp_valid, lsu_resp_rdata);
        end
        lsu_req_wen = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        ifu_flush = 1'b1;
        tick();
        ifu_flush = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL flush_drop got=%b want=00", {ifu_resp_valid, busy});
        end
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0008;
        tick();
        ifu_req_valid = 1'b0;
        mem_cycle(32'h0010_0093);
        total++;
        if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'h0010_0093}) begin
            bad++;
            $display("FAIL flush_next got=%b %h want=1 00100093",
                     ifu_resp_valid, ifu_resp_data);
        end
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_000C;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_0000;
        ifu_flush      = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL flush_same got=%b want=00", {ifu_resp_valid, busy});
        end
        ifu_req_valid = 1'b1;
        #1;
        total++;
        if (ifu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle got=%b want=0", ifu_req_ready);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_busy got=%b want=0", busy);
        end
        ifu_req_valid = 1'b0;
        ifu_flush     = 1'b0;
        tick();
    endtask

    task automatic test_spurious();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hFFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        total++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL spurious got=%b want=000",
                     {ifu_resp_valid, lsu_resp_valid, busy});
        end
        tick();
    endtask

    task automatic test_async_reset();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0040;
        tick();
        lsu_req_valid = 1'b0;
        total++;
        if ({mem_req_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL areset_pre got=%b want=11", {mem_req_valid, busy});
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({mem_req_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL areset_drop got=%b want=00", {mem_req_valid, busy});
        end
        tick();
        rst = 1'b1;
        tick();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        total++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL areset_tie got=%b want=10",
                     {lsu_req_ready, ifu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_cycle(32'h0);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_collision();
        test_single_fetch();
        test_store();
        test_flush();
        test_spurious();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
